stim_checker: RTL and testbench
===============================

Name: stim_checker

Overview:
- Downstream consumer of the directed-test stimulus stage.
- Watches the per-test start event, the test select and the stimulus lines a/b.
- Checks that a and b follow the expected pattern for the selected test: value, delay and ordering.
- Reports pass/fail per test plus running counters for the save/restore regression bench.

Parameters:
- DLY_SHORT, 2, cycles from start to expected b update for tests 0, 1, 2.
- DLY_LONG, 4, cycles from start to expected b update for test 3.
- CNT_W, 8, width of test/pass counters.

Ports:
- clk  input  1  clock, checks on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse, one per test (the after-reset event).
- select  input  4  test number, sampled with start.
- a  input  1  stimulus line a.
- b  input  1  stimulus line b.
- busy  output  1  high while a test is being checked.
- done  output  1  one-cycle pulse when a verdict is produced.
- pass  output  1  verdict of last completed test, sticky.
- fail  output  1  verdict of last completed test, sticky; pass and fail are never both 1.
- err_code  output  3  reason for last fail: 0 none, 1 A_MISMATCH, 2 B_EARLY, 3 B_MISMATCH, 4 ILLEGAL_SEL, 5 ABORT.
- test_cnt  output  CNT_W  verdicts produced, saturating.
- pass_cnt  output  CNT_W  passing verdicts, saturating.

Behaviour:
- Reset: asynchronous, active-high, takes effect immediately including mid-test. All outputs go to 0; FSM goes to IDLE; captured select, expectations and cycle counter k are cleared.
- Expected table, indexed by select:
  - 0: exp_a=1, exp_b=1, D=DLY_SHORT.
  - 1: exp_a=0, exp_b=1, D=DLY_SHORT.
  - 2: exp_a=1, exp_b=0, D=DLY_SHORT.
  - 3: exp_a=1, exp_b=1, D=DLY_LONG.
  - 4..15: illegal.
- FSM states: IDLE, CHECK, VERDICT.
- IDLE:
  - start=1 with a legal select: capture exp_a/exp_b/D, k:=1, go to CHECK, busy=1 from the next cycle.
  - start=1 with an illegal select: go to VERDICT with fail, err=4.
- CHECK, once per cycle k:
  - k=1: a must equal exp_a, else fail, err=1.
  - k in 1..D: b must equal 0, else fail, err=2. If a is also wrong at k=1, err=1 takes priority.
  - k=D+1: b must equal exp_b, else fail, err=3.
  - Passing k=D+1 without error: verdict pass, err=0.
  - First error ends the check immediately, with no further sampling.
  - a is checked only at k=1; later a changes are ignored.
- VERDICT, one cycle:
  - done=1; pass/fail/err_code registered.
  - test_cnt+1, and pass_cnt+1 on pass; both saturate at all-ones.
  - busy=0; return to IDLE.
- Latency, with cycle 0 = the start cycle:
  - pass: done visible in cycle D+2.
  - err 1/2 at k: done visible in cycle k+1.
  - illegal select: done visible in cycle 1.
- start while in CHECK: the current test ends with fail, err=5, done in the next cycle. The new start is not accepted and must be re-issued.
- start in the VERDICT cycle: accepted as in IDLE, overlapping the done pulse.
- pass/fail/err_code hold until the next verdict; a new start does not clear them.
- Counter k width: clog2(max(DLY_SHORT, DLY_LONG)+2); no wrap in valid operation.

Decomposition:
- Package stim_chk_pkg holds:
  - state_t enum (IDLE, CHECK, VERDICT).
  - err_t enum (codes 0..5).
  - the exp_t struct {exp_a, exp_b, is_long}.
  - a function lookup_exp(select) returning exp_t plus a legal flag.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc), instantiated twice for test_cnt and pass_cnt.

Test Plan:
- rst=1 pulse mid-CHECK of test 3 at k=2 → all outputs 0 immediately, FSM IDLE; the next start with select=0 is checked normally.
- select=0; start; a=1 at k=1; b=0 for k=1..2; b=1 at k=3 → done in cycle 4, pass=1, err_code=0, test_cnt=1, pass_cnt=1.
- select=3; a=1; b rises at k=3 instead of k=5 → done in cycle 4, fail=1, err_code=2, pass_cnt unchanged.
- select=1 with a=1 at k=1 → done in cycle 2, fail=1, err_code=1. Then select=2, a=1, b=0 throughout → pass, err_code=0.
- select=4'h7; start → done in cycle 1, fail=1, err_code=4, busy never asserted.
- select=0; second start at k=2 → done next cycle, fail=1, err_code=5, second test not started. Then 300 passing tests → test_cnt and pass_cnt saturate at 255.

Source files
------------

// File: rtl/stim_chk_pkg.sv
// Shared types and the per-test expectation table for the stimulus checker.
package stim_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        VERDICT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_A_MISMATCH  = 3'd1,
        ERR_B_EARLY     = 3'd2,
        ERR_B_MISMATCH  = 3'd3,
        ERR_ILLEGAL_SEL = 3'd4,
        ERR_ABORT       = 3'd5
    } err_t;

    // Expected stimulus for one test; is_long picks the long b delay.
    typedef struct packed {
        logic exp_a;
        logic exp_b;
        logic is_long;
    } exp_t;

    typedef struct packed {
        logic legal;
        exp_t exp;
    } lut_t;

    // Map a test number onto its expected a/b values and delay class.
    function automatic lut_t lookup_exp(input logic [3:0] sel);
        lut_t r;
        r = '0;
        case (sel)
            4'd0: r = '{legal: 1'b1, exp: '{exp_a: 1'b1, exp_b: 1'b1, is_long: 1'b0}};
            4'd1: r = '{legal: 1'b1, exp: '{exp_a: 1'b0, exp_b: 1'b1, is_long: 1'b0}};
            4'd2: r = '{legal: 1'b1, exp: '{exp_a: 1'b1, exp_b: 1'b0, is_long: 1'b0}};
            4'd3: r = '{legal: 1'b1, exp: '{exp_a: 1'b1, exp_b: 1'b1, is_long: 1'b1}};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count increments, holding once the maximum is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/stim_checker.sv
// Checks a/b stimulus against the selected test's expected value, delay
// and ordering, and reports a sticky verdict plus saturating counters.
module stim_checker
    import stim_chk_pkg::*;
#(
    parameter int DLY_SHORT = 2,
    parameter int DLY_LONG  = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       select,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] test_cnt,
    output logic [CNT_W-1:0] pass_cnt
);

    localparam int DMAX = (DLY_SHORT > DLY_LONG) ? DLY_SHORT : DLY_LONG;
    localparam int KW   = $clog2(DMAX + 2);
    localparam logic [KW-1:0] D_SHORT = KW'(DLY_SHORT);
    localparam logic [KW-1:0] D_LONG  = KW'(DLY_LONG);

    state_t        state, state_n;
    exp_t          exp_q, exp_n;
    logic [KW-1:0] k, k_n;
    logic [KW-1:0] d_cur;
    lut_t          lut;
    logic          vrd;
    err_t          vrd_err, err_q;

    assign lut   = lookup_exp(select);
    assign d_cur = exp_q.is_long ? D_LONG : D_SHORT;

    // Next-state logic: accept tests, sample a/b per cycle, pick the verdict.
    // A start seen during CHECK aborts the running test ahead of any
    // sampling error in that same cycle.
    always_comb begin
        state_n = state;
        exp_n   = exp_q;
        k_n     = k;
        vrd     = 1'b0;
        vrd_err = ERR_NONE;
        case (state)
            IDLE, VERDICT: begin
                state_n = IDLE;
                if (start) begin
                    if (lut.legal) begin
                        state_n = CHECK;
                        exp_n   = lut.exp;
                        k_n     = KW'(1);
                    end else begin
                        state_n = VERDICT;
                        vrd     = 1'b1;
                        vrd_err = ERR_ILLEGAL_SEL;
                    end
                end
            end
            CHECK: begin
                if (start) begin
                    vrd     = 1'b1;
                    vrd_err = ERR_ABORT;
                end else if ((k == KW'(1)) && (a != exp_q.exp_a)) begin
                    vrd     = 1'b1;
                    vrd_err = ERR_A_MISMATCH;
                end else if ((k <= d_cur) && b) begin
                    vrd     = 1'b1;
                    vrd_err = ERR_B_EARLY;
                end else if (k == d_cur + KW'(1)) begin
                    vrd     = 1'b1;
                    vrd_err = (b == exp_q.exp_b) ? ERR_NONE : ERR_B_MISMATCH;
                end else begin
                    k_n = k + KW'(1);
                end
                if (vrd)
                    state_n = VERDICT;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state, captured expectation and in-test cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            exp_q <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            exp_q <= exp_n;
            k     <= k_n;
        end
    end

    // Sticky verdict, updated on the edge that enters VERDICT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass  <= 1'b0;
            fail  <= 1'b0;
            err_q <= ERR_NONE;
        end else if (vrd) begin
            pass  <= (vrd_err == ERR_NONE);
            fail  <= (vrd_err != ERR_NONE);
            err_q <= vrd_err;
        end
    end

    assign busy     = (state == CHECK);
    assign done     = (state == VERDICT);
    assign err_code = err_q;

    // Counters bump on the same edge as the verdict so they line up with done.
    sat_counter #(.W(CNT_W)) u_test_cnt (
        .clk (clk),
        .rst (rst),
        .inc (vrd),
        .cnt (test_cnt)
    );

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .inc (vrd && (vrd_err == ERR_NONE)),
        .cnt (pass_cnt)
    );

endmodule

// File: tb/tb_stim_checker.sv
// Bench for stim_checker: directed table, reset/abort/saturation sequences,
// and randomized tests scored against a reference model.
module tb_stim_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] select = '0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       busy, done, pass, fail;
    logic [2:0] err_code;
    logic [7:0] test_cnt, pass_cnt;

    int n_err = 0;
    int n_chk = 0;
    int exp_tc = 0;
    int exp_pc = 0;

    stim_checker dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .select   (select),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .err_code (err_code),
        .test_cnt (test_cnt),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] av;      // bit c = a driven in cycle c
        logic [7:0] bv;      // bit c = b driven in cycle c
        int         ab;      // cycle of an aborting start, 0 = none
        int         err;
        int         dc;      // cycle in which done is expected
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model from the test rules: earliest of a-mismatch, first
    // early b, final b check; an abort at or before that point wins.
    function automatic void model(input logic [3:0] sel, input logic [7:0] av,
                                  input logic [7:0] bv, input int ab,
                                  output int err, output int dc);
        logic ea, eb;
        int   d, t, e;
        case (sel)
            4'd0: begin ea = 1; eb = 1; d = 2; end
            4'd1: begin ea = 0; eb = 1; d = 2; end
            4'd2: begin ea = 1; eb = 0; d = 2; end
            4'd3: begin ea = 1; eb = 1; d = 4; end
            default: begin err = 4; dc = 1; return; end
        endcase
        if (av[1] != ea) begin
            e = 1; t = 1;
        end else begin
            t = d + 1;
            e = (bv[d+1] == eb) ? 0 : 3;
            for (int k = d; k >= 1; k--)
                if (bv[k]) begin t = k; e = 2; end
        end
        if (ab >= 1 && ab <= t) begin e = 5; t = ab; end
        err = e;
        dc  = t + 1;
    endfunction

    // Runs one test starting in the current cycle (FSM idle, #1 after an edge).
    task automatic run_test(input string id, input logic [3:0] sel,
                            input logic [7:0] av, input logic [7:0] bv,
                            input int ab, input int err, input int dc);
        logic legal;
        legal  = (sel < 4);
        start  = 1'b1;
        select = sel;
        a      = av[0];
        b      = bv[0];
        for (int c = 1; c <= dc; c++) begin
            @(posedge clk); #1;
            start = (c == ab) && (c < dc);
            a     = av[c];
            b     = bv[c];
            if (c < dc) begin
                chk({id, " done_early"}, int'(done), 0);
                chk({id, " busy"}, int'(busy), int'(legal));
            end else begin
                if (exp_tc < 255) exp_tc++;
                if (err == 0 && exp_pc < 255) exp_pc++;
                chk({id, " done"}, int'(done), 1);
                chk({id, " busy_at_done"}, int'(busy), 0);
                chk({id, " pass"}, int'(pass), int'(err == 0));
                chk({id, " fail"}, int'(fail), int'(err != 0));
                chk({id, " err_code"}, int'(err_code), err);
                chk({id, " test_cnt"}, int'(test_cnt), exp_tc);
                chk({id, " pass_cnt"}, int'(pass_cnt), exp_pc);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({id, " post_done"}, int'(done), 0);
        chk({id, " post_busy"}, int'(busy), 0);
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{4'd0,  8'h02, 8'h08, 0, 0, 4};  // sel0 pass
        tbl[1]  = '{4'd3,  8'h02, 8'h08, 0, 2, 4};  // sel3 b early at k3
        tbl[2]  = '{4'd1,  8'h02, 8'h00, 0, 1, 2};  // sel1 a wrong
        tbl[3]  = '{4'd2,  8'h02, 8'h00, 0, 0, 4};  // sel2 pass, b stays low
        tbl[4]  = '{4'd7,  8'h00, 8'h00, 0, 4, 1};  // illegal select
        tbl[5]  = '{4'd0,  8'h02, 8'h00, 2, 5, 3};  // abort at k2
        tbl[6]  = '{4'd3,  8'h02, 8'h20, 0, 0, 6};  // sel3 pass
        tbl[7]  = '{4'd3,  8'h02, 8'h00, 0, 3, 6};  // sel3 b never rises
        tbl[8]  = '{4'd0,  8'h00, 8'h02, 0, 1, 2};  // a wrong and b early: a wins
        tbl[9]  = '{4'd1,  8'h00, 8'h08, 0, 0, 4};  // sel1 pass
        tbl[10] = '{4'd15, 8'h00, 8'h00, 0, 4, 1};  // illegal select
        tbl[11] = '{4'd0,  8'h0E, 8'h08, 0, 0, 4};  // late a changes ignored
        tbl[12] = '{4'd1,  8'h00, 8'h04, 0, 2, 3};  // sel1 b early at k2
        tbl[13] = '{4'd2,  8'h02, 8'h08, 0, 3, 4};  // sel2 b high at k3

        // Reset state, asynchronous before any clock edge.
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst pass", int'(pass), 0);
        chk("rst fail", int'(fail), 0);
        chk("rst err_code", int'(err_code), 0);
        chk("rst test_cnt", int'(test_cnt), 0);
        chk("rst pass_cnt", int'(pass_cnt), 0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 14; i++)
            run_test($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].av, tbl[i].bv,
                     tbl[i].ab, tbl[i].err, tbl[i].dc);

        // Reset in the middle of a select=3 check at k=2.
        start = 1'b1; select = 4'd3; a = 1'b0; b = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = 1'b1; b = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst pass", int'(pass), 0);
        chk("midrst fail", int'(fail), 0);
        chk("midrst err_code", int'(err_code), 0);
        chk("midrst test_cnt", int'(test_cnt), 0);
        chk("midrst pass_cnt", int'(pass_cnt), 0);
        exp_tc = 0;
        exp_pc = 0;
        #1 rst = 1'b0;
        a = 1'b0;
        @(posedge clk); #1;
        chk("midrst idle_busy", int'(busy), 0);
        run_test("after_rst", 4'd0, 8'h02, 8'h08, 0, 0, 4);

        // Randomized tests: mostly well-formed stimulus with occasional faults.
        for (int i = 0; i < 150; i++) begin
            logic [3:0] sel;
            logic [7:0] av, bv;
            int ab, err, dc, d;
            sel = 4'($urandom_range(0, 5));
            d   = (sel == 3) ? 4 : 2;
            av  = '0;
            bv  = '0;
            av[1] = (sel != 1);
            bv[d+1] = (sel != 2);
            av = av | (8'($urandom) & 8'hFC);
            if ($urandom_range(0, 3) == 0) av[1] = ~av[1];
            if ($urandom_range(0, 3) == 0) bv[$urandom_range(1, 6)] = 1'b1;
            if ($urandom_range(0, 3) == 0) bv[d+1] = ~bv[d+1];
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0;
            model(sel, av, bv, ab, err, dc);
            run_test($sformatf("rnd%0d", i), sel, av, bv, ab, err, dc);
        end

        // Saturation: drive enough passing tests to pin both counters.
        for (int i = 0; i < 300; i++)
            run_test($sformatf("sat%0d", i), 4'd0, 8'h02, 8'h08, 0, 0, 4);
        chk("sat test_cnt", int'(test_cnt), 255);
        chk("sat pass_cnt", int'(pass_cnt), 255);
        run_test("sat_fail", 4'd1, 8'h02, 8'h00, 0, 1, 2);
        chk("sat_fail test_cnt", int'(test_cnt), 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
